// File: rtl/multi_ch_trig_if.sv
// rtl/multi_ch_trig_if.sv - sample/config/trigger bundle for multi_ch_trig
// master drives samples and config; slave returns trigger results.
interface multi_ch_trig_if #(
  parameter int NCH = 2,
  parameter int DW  = 14,
  parameter int CW  = 16
);
  logic [NCH*DW-1:0] tdat;
  logic [DW-1:0]     thres;
  logic [NCH-1:0]    ch_en;
  logic              mode_edge;
  logic              mode_and;
  logic              trig;
  logic [NCH-1:0]    trig_ch;
  logic              busy;
  logic [CW-1:0]     trig_cnt;

  modport master (
    output tdat, thres, ch_en, mode_edge, mode_and,
    input  trig, trig_ch, busy, trig_cnt
  );

  modport slave (
    input  tdat, thres, ch_en, mode_edge, mode_and,
    output trig, trig_ch, busy, trig_cnt
  );
endinterface

// File: rtl/multi_ch_trig.sv
// rtl/multi_ch_trig.sv - multi-channel threshold trigger with coincidence and holdoff
// Stage 1 registers per-channel hits; stage 2 FSM combines them and paces triggers.
module multi_ch_trig #(
  parameter int NCH       = 2,
  parameter int DW        = 14,
  parameter int HOLDOFF   = 10,
  parameter int COINC_WIN = 4,
  parameter int CW        = 16
) (
  input logic           clk,
  input logic           rst,
  multi_ch_trig_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COINC, HOLD} state_t;

  localparam logic [15:0] H_LAST = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);
  localparam logic [15:0] W_LAST = 16'(COINC_WIN - 1);

  logic [NCH-1:0] hit;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] cur;
    logic [DW-1:0] prev;
    logic          lvl;
    logic          hit_r;

    assign cur    = bus.tdat[i*DW +: DW];
    assign lvl    = (cur >= bus.thres);
    assign hit[i] = hit_r;

    // prev resets high so edge mode must first see a below-threshold sample
    always_ff @(posedge clk) begin
      if (rst) begin
        prev  <= '1;
        hit_r <= 1'b0;
      end else begin
        prev  <= cur;
        hit_r <= bus.ch_en[i] & (bus.mode_edge ? (lvl & (prev < bus.thres)) : lvl);
      end
    end
  end

  state_t         state, state_nx;
  logic [NCH-1:0] latch, latch_nx;
  logic [NCH-1:0] acc;
  logic [15:0]    wcnt, wcnt_nx;
  logic [15:0]    hcnt, hcnt_nx;
  logic           fire;
  logic [NCH-1:0] fire_ch;
  logic           trig_q;
  logic [NCH-1:0] trig_ch_q;
  logic [CW-1:0]  cnt_q;

  always_comb begin
    state_nx = state;
    latch_nx = latch;
    wcnt_nx  = wcnt;
    hcnt_nx  = hcnt;
    fire     = 1'b0;
    fire_ch  = '0;
    acc      = latch | hit;
    case (state)
      IDLE: begin
        if (!bus.mode_and) begin
          if (|hit) begin
            fire    = 1'b1;
            fire_ch = hit;
          end
        end else if (bus.ch_en != '0) begin
          if ((hit & bus.ch_en) == bus.ch_en) begin
            fire    = 1'b1;
            fire_ch = hit;
          end else if (|(hit & bus.ch_en)) begin
            state_nx = COINC;
            latch_nx = hit;
            wcnt_nx  = '0;
          end
        end
      end
      COINC: begin
        if (!bus.mode_and || bus.ch_en == '0) begin
          state_nx = IDLE;
          latch_nx = '0;
        end else if ((acc & bus.ch_en) == bus.ch_en) begin
          fire     = 1'b1;
          fire_ch  = acc;
          latch_nx = '0;
        end else if (wcnt == W_LAST) begin
          state_nx = IDLE;
          latch_nx = '0;
        end else begin
          latch_nx = acc;
          wcnt_nx  = wcnt + 16'd1;
        end
      end
      HOLD: begin
        if (hcnt == H_LAST) state_nx = IDLE;
        else                hcnt_nx  = hcnt + 16'd1;
      end
      default: state_nx = IDLE;
    endcase
    if (fire) begin
      state_nx = HOLD;
      hcnt_nx  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      latch     <= '0;
      wcnt      <= '0;
      hcnt      <= '0;
      trig_q    <= 1'b0;
      trig_ch_q <= '0;
      cnt_q     <= '0;
    end else begin
      state  <= state_nx;
      latch  <= latch_nx;
      wcnt   <= wcnt_nx;
      hcnt   <= hcnt_nx;
      trig_q <= fire;
      if (fire) trig_ch_q <= fire_ch;
      if (fire && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.trig     = trig_q;
  assign bus.trig_ch  = trig_ch_q;
  assign bus.busy     = (state != IDLE);
  assign bus.trig_cnt = cnt_q;
endmodule

// File: doc/multi_ch_trig.md
Name: multi_ch_trig

Overview:
- Parametrised multi-channel threshold trigger for the dual-ADC front end.
- Compares each channel's ADC sample against a runtime threshold, in level or rising-edge mode.
- Combines the channel hits as OR, or as AND within a coincidence window.
- Emits a one-cycle trigger pulse with the hit-channel mask and enforces a programmable holdoff; also keeps a saturating trigger counter for the readout logic.

Parameters:
- NCH, 2, number of ADC channels (1..8).
- DW, 14, ADC sample width in bits; samples are unsigned.
- HOLDOFF, 10, cycles spent in HOLD after each trigger (0..65535).
- COINC_WIN, 4, AND-mode coincidence window in cycles (>=1).
- CW, 16, trigger counter width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- tdat  in  NCH*DW  packed samples; channel i occupies bits [i*DW +: DW].
- thres  in  DW  common threshold; unsigned compare, hit when sample >= thres.
- ch_en  in  NCH  per-channel enable mask.
- mode_edge  in  1  0 = level hit; 1 = rising-crossing hit (prev < thres and cur >= thres).
- mode_and  in  1  0 = OR of enabled hits; 1 = all enabled channels within COINC_WIN.
- trig  out  1  one-cycle trigger pulse.
- trig_ch  out  NCH  mask of channels contributing to the last trigger.
- busy  out  1  high while in COINC or HOLD.
- trig_cnt  out  CW  number of triggers since reset; saturates at all-ones.

Behaviour:
- Reset values: trig=0, trig_ch=0, busy=0, trig_cnt=0, state=IDLE, latched hits=0. Each prev[i] resets to all-ones, so edge mode needs one below-threshold sample after reset before it can fire.
- Stage 1 (registered, every cycle, independent of state):
  - hit[i] <= ch_en[i] & (mode_edge ? (cur>=thres & prev[i]<thres) : cur>=thres).
  - prev[i] <= cur.
  - Config inputs are sampled every cycle; no shadowing.
- Stage 2 FSM, states IDLE, COINC, HOLD. Latency: sample at edge N gives trig high during the cycle after edge N+1.
- IDLE:
  - OR mode and any hit: trig=1, trig_ch=hit, go HOLD.
  - AND mode and (hit & ch_en)==ch_en with ch_en!=0: trig=1, trig_ch=hit, go HOLD.
  - AND mode with some but not all enabled channels hit: latch=hit, wcnt=0, go COINC.
  - Otherwise stay.
- COINC:
  - latch |= hit each cycle.
  - If (latch|hit) covers ch_en: trig=1, trig_ch=latch|hit, clear latch, go HOLD.
  - Else if wcnt==COINC_WIN-1: clear latch, go IDLE, no trigger.
  - Else wcnt++.
  - If ch_en becomes 0 or mode_and drops to 0: clear latch, go IDLE.
- HOLD:
  - Hits are ignored and discarded, not queued.
  - Counter runs HOLDOFF cycles, then IDLE.
  - HOLDOFF=0 returns to IDLE the cycle after trig.
- trig is high for exactly one cycle per trigger. trig_ch holds its value until the next trigger.
- trig_cnt increments on each trig; it holds at 2^CW-1 once saturated.
- busy = state!=IDLE.
- Boundaries:
  - ch_en=0 never triggers.
  - thres=0: level mode hits every cycle on enabled channels; edge mode never hits.
  - In AND mode, a single enabled channel behaves as OR.
  - A hit arriving in the same cycle as window expiry still counts and can trigger.
  - rst asserted mid-operation returns everything to reset values on the next edge; any pending coincidence is lost.

Test Plan:
- Level OR: NCH=2, thres=1000, ch_en=11, ch0 steps 0->1200 -> trig 2 cycles later, trig_ch=01, busy for 10 cycles, trig_cnt=1; sample held high re-triggers every 11 cycles.
- Edge mode: ch1 held at 1200 then 900 then 1200, thres=1000 -> exactly one trig, on the 900->1200 crossing; sample held at 1200 gives no further triggers.
- AND coincidence: COINC_WIN=4, ch0 crosses at t, ch1 at t+3 -> trig with trig_ch=11; repeat with ch1 at t+5 -> no trig, FSM back to IDLE.
- Holdoff discard: HOLDOFF=10, second crossing 5 cycles after trig -> ignored; crossing 12 cycles after -> triggers.
- Saturation: CW=4, 20 triggers -> trig_cnt stops at 15.
- Reset: assert rst while in COINC -> next cycle state IDLE, outputs 0, latch cleared; ch_en=0 with large samples -> no trig.
